hls_deadlock_reporter: RTL



---
 rtl/hls_deadlock_pkg.sv | 7 +
 rtl/hls_deadlock_confirm_ctr.sv | 17 +
 rtl/hls_deadlock_reporter.sv | 91 +++++++++
 3 files changed

// File: rtl/hls_deadlock_pkg.sv
// hls_deadlock_pkg: shared state, constants and types for the deadlock reporter
package hls_deadlock_pkg;
    typedef enum logic [1:0] {IDLE, CONFIRM, SEND, DONE} state_t;
    localparam logic [7:0] REPORT_MAGIC = 8'hDE;
    localparam int REPORT_WORDS = 6;
    typedef logic [2:0] word_idx_t;
endpackage

// File: rtl/hls_deadlock_confirm_ctr.sv
// hls_deadlock_confirm_ctr: qualifies block as held for CONFIRM_CYCLES consecutive cycles
module hls_deadlock_confirm_ctr #(
    parameter int CONFIRM_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic block,
    input  logic enable,
    output logic confirmed
);
    localparam int CW = CONFIRM_CYCLES > 1 ? $clog2(CONFIRM_CYCLES) : 1;
    logic [CW-1:0] cnt;
    assign confirmed = enable && block && cnt == CW'(CONFIRM_CYCLES - 1);
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (enable && block && !confirmed) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/hls_deadlock_reporter.sv
// hls_deadlock_reporter: confirms a deadlock, snapshots the block vectors and streams a 6-word report
module hls_deadlock_reporter
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_PROC       = 17,
    parameter int AXIS_W         = 7,
    parameter int CONFIRM_CYCLES = 16,
    parameter int WORD_W         = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block,
    input  logic [NUM_PROC-1:0] process_idle_vec,
    input  logic [NUM_PROC-1:0] process_chan_block_vec,
    input  logic [NUM_PROC-1:0] process_axis_block_vec,
    input  logic [AXIS_W-1:0]   axis_block_sigs,
    input  logic                clear,
    output logic [WORD_W-1:0]   rpt_tdata,
    output logic                rpt_tvalid,
    input  logic                rpt_tready,
    output logic                rpt_tlast,
    output logic                deadlock_flag,
    output logic [15:0]         event_count
);
    state_t state;
    word_idx_t idx;
    logic [31:0] ts, ts_snap;
    logic [NUM_PROC-1:0] idle_snap, chan_snap, axisb_snap;
    logic [AXIS_W-1:0] sigs_snap;
    logic confirmed;
    hls_deadlock_confirm_ctr #(.CONFIRM_CYCLES(CONFIRM_CYCLES)) u_ctr (
        .clock(clock),
        .reset(reset),
        .block(block),
        .enable(state == IDLE || state == CONFIRM),
        .confirmed(confirmed)
    );
    always_comb
        rpt_tdata = !rpt_tvalid ? '0 :
                    idx == 3'd0 ? WORD_W'({REPORT_MAGIC, 8'(NUM_PROC), event_count}) :
                    idx == 3'd1 ? WORD_W'(idle_snap) :
                    idx == 3'd2 ? WORD_W'(chan_snap) :
                    idx == 3'd3 ? WORD_W'(axisb_snap) :
                    idx == 3'd4 ? WORD_W'(sigs_snap) : WORD_W'(ts_snap);
    assign rpt_tlast = rpt_tvalid && idx == word_idx_t'(REPORT_WORDS - 1);
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            ts            <= '0;
            ts_snap       <= '0;
            idle_snap     <= '0;
            chan_snap     <= '0;
            axisb_snap    <= '0;
            sigs_snap     <= '0;
            rpt_tvalid    <= 1'b0;
            deadlock_flag <= 1'b0;
            event_count   <= '0;
        end else begin
            ts <= ts + 1'b1;
            case (state)
                IDLE, CONFIRM:
                    if (confirmed) begin
                        state         <= SEND;
                        idle_snap     <= process_idle_vec;
                        chan_snap     <= process_chan_block_vec;
                        axisb_snap    <= process_axis_block_vec;
                        sigs_snap     <= axis_block_sigs;
                        ts_snap       <= ts;
                        deadlock_flag <= 1'b1;
                        rpt_tvalid    <= 1'b1;
                        idx           <= '0;
                        if (event_count != 16'hFFFF) event_count <= event_count + 1'b1;
                    end else state <= block ? CONFIRM : IDLE;
                SEND:
                    if (rpt_tready) begin
                        idx <= idx + 1'b1;
                        if (idx == word_idx_t'(REPORT_WORDS - 1)) begin
                            state      <= DONE;
                            rpt_tvalid <= 1'b0;
                        end
                    end
                DONE:
                    if (clear) begin
                        state         <= IDLE;
                        deadlock_flag <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule
